matrix_code_dec_pipe: RTL and testbench

Parametrised, pipelined matrix-code decoder: the next-generation space-ECC receive block. It accepts product-code codewords of ROWS×COLS data bits protected by row parity, column parity and an overall parity bit. It corrects any single-bit error, including errors in check bits, and flags double errors. It sits between the memory/link read path and the consumer, with valid/ready flow control on both sides and optional error-event counters.

---
 rtl/mcd_pkg.sv | 14 +
 rtl/mcd_syndrome.sv | 30 +++
 rtl/matrix_code_dec_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_matrix_code_dec_pipe.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcd_pkg.sv
// Shared definitions for the matrix-code decoder: status encodings and codeword sizing.
package mcd_pkg;

  localparam logic [1:0] MCD_CLEAN     = 2'b00;
  localparam logic [1:0] MCD_CORR_DATA = 2'b01;
  localparam logic [1:0] MCD_CORR_CHK  = 2'b10;
  localparam logic [1:0] MCD_UNCORR    = 2'b11;

  // Data bits plus one parity per row, one per column and the overall parity.
  function automatic int unsigned mcd_cw_w(input int unsigned rows, input int unsigned cols);
    return rows * cols + rows + cols + 1;
  endfunction

endpackage

// File: rtl/mcd_syndrome.sv
// Row/column/overall parity syndrome of a product-code codeword (shared with the encoder).
module mcd_syndrome
  import mcd_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4
) (
  input  logic [mcd_cw_w(ROWS, COLS)-1:0] in_cw,
  output logic [ROWS-1:0]                 sr,
  output logic [COLS-1:0]                 sc,
  output logic                            so
);

  localparam int unsigned DATA_W = ROWS * COLS;

  always_comb begin
    sr = '0;
    sc = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        sr[r] = sr[r] ^ in_cw[r*COLS+c];
        sc[c] = sc[c] ^ in_cw[r*COLS+c];
      end
    end
    for (int unsigned r = 0; r < ROWS; r++) sr[r] = sr[r] ^ in_cw[DATA_W+r];
    for (int unsigned c = 0; c < COLS; c++) sc[c] = sc[c] ^ in_cw[DATA_W+ROWS+c];
    so = ^in_cw;
  end

endmodule

// File: rtl/matrix_code_dec_pipe.sv
// Two-stage pipelined product-code decoder with valid/ready on both sides.
// Define MCD_ERR_CNT_EN to build the saturating error-event counters.
module matrix_code_dec_pipe
  import mcd_pkg::*;
#(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [mcd_cw_w(ROWS, COLS)-1:0] in_cw,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ROWS*COLS-1:0]            out_data,
  output logic [1:0]                      out_status,
  output logic [$clog2(ROWS)-1:0]         out_err_row,
  output logic [$clog2(COLS)-1:0]         out_err_col,
  input  logic                            cnt_clr,
  output logic [CNT_W-1:0]                corr_cnt,
  output logic [CNT_W-1:0]                uncorr_cnt
);

  localparam int unsigned DATA_W = ROWS * COLS;
  localparam int unsigned RW     = $clog2(ROWS);
  localparam int unsigned CLW    = $clog2(COLS);

  logic [ROWS-1:0] sr_c;
  logic [COLS-1:0] sc_c;
  logic            so_c;

  mcd_syndrome #(.ROWS(ROWS), .COLS(COLS)) u_syn (
    .in_cw (in_cw),
    .sr    (sr_c),
    .sc    (sc_c),
    .so    (so_c)
  );

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [ROWS-1:0]   s1_sr_q, s1_sr_d;
  logic [COLS-1:0]   s1_sc_q, s1_sc_d;
  logic              s1_so_q, s1_so_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_status_q, out_status_d;
  logic [RW-1:0]     out_err_row_q, out_err_row_d;
  logic [CLW-1:0]    out_err_col_q, out_err_col_d;

  logic              en1_c, en2_c;
  logic [DATA_W-1:0] flip_c;
  logic [RW-1:0]     row_idx_c;
  logic [CLW-1:0]    col_idx_c;
  logic              sr_one_c, sc_one_c, sr_zero_c, sc_zero_c;

  // Stage enables: a stage advances when its downstream slot is free or draining.
  always_comb begin
    en2_c = !out_valid_q || out_ready;
    en1_c = !s1_valid_q || en2_c;
  end

  assign in_ready = en1_c;

  // Error localisation and classification from the registered syndromes.
  always_comb begin
    flip_c    = '0;
    row_idx_c = '0;
    col_idx_c = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (s1_sr_q[r]) row_idx_c = RW'(r);
      for (int unsigned c = 0; c < COLS; c++) begin
        flip_c[r*COLS+c] = s1_sr_q[r] & s1_sc_q[c];
      end
    end
    for (int unsigned c = 0; c < COLS; c++) begin
      if (s1_sc_q[c]) col_idx_c = CLW'(c);
    end
    sr_one_c  = $onehot(s1_sr_q);
    sc_one_c  = $onehot(s1_sc_q);
    sr_zero_c = (s1_sr_q == '0);
    sc_zero_c = (s1_sc_q == '0);
  end

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_data_d     = s1_data_q;
    s1_sr_d       = s1_sr_q;
    s1_sc_d       = s1_sc_q;
    s1_so_d       = s1_so_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_status_d  = out_status_q;
    out_err_row_d = out_err_row_q;
    out_err_col_d = out_err_col_q;

    if (en1_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_cw[DATA_W-1:0];
        s1_sr_d   = sr_c;
        s1_sc_d   = sc_c;
        s1_so_d   = so_c;
      end
    end

    if (en2_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d    = s1_data_q;
        out_err_row_d = '0;
        out_err_col_d = '0;
        if (!s1_so_q && sr_zero_c && sc_zero_c) begin
          out_status_d = MCD_CLEAN;
        end else if (s1_so_q && sr_one_c && sc_one_c) begin
          out_status_d  = MCD_CORR_DATA;
          out_data_d    = s1_data_q ^ flip_c;
          out_err_row_d = row_idx_c;
          out_err_col_d = col_idx_c;
        end else if (s1_so_q && ((sr_zero_c && (sc_zero_c || sc_one_c)) ||
                                 (sc_zero_c && sr_one_c))) begin
          out_status_d = MCD_CORR_CHK;
        end else begin
          out_status_d = MCD_UNCORR;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_data_q     <= '0;
      s1_sr_q       <= '0;
      s1_sc_q       <= '0;
      s1_so_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_status_q  <= MCD_CLEAN;
      out_err_row_q <= '0;
      out_err_col_q <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_data_q     <= s1_data_d;
      s1_sr_q       <= s1_sr_d;
      s1_sc_q       <= s1_sc_d;
      s1_so_q       <= s1_so_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_status_q  <= out_status_d;
      out_err_row_q <= out_err_row_d;
      out_err_col_q <= out_err_col_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_status  = out_status_q;
  assign out_err_row = out_err_row_q;
  assign out_err_col = out_err_col_q;

`ifdef MCD_ERR_CNT_EN
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;
  logic             hs_c;

  // Saturating counts of delivered words; clear wins over a same-cycle increment.
  always_comb begin
    hs_c         = out_valid_q && out_ready;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (hs_c) begin
      if (out_status_q == MCD_UNCORR) begin
        if (uncorr_cnt_q != '1) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
      end else if (out_status_q != MCD_CLEAN) begin
        if (corr_cnt_q != '1) corr_cnt_d = corr_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_matrix_code_dec_pipe.sv
// Scoreboard bench for matrix_code_dec_pipe (4x4, CNT_W=2); follows MCD_ERR_CNT_EN if defined.
module tb_matrix_code_dec_pipe;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned CW_W  = 25;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_cw;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_status;
  logic [1:0]  out_err_row;
  logic [1:0]  out_err_col;
  logic        cnt_clr;
  logic [1:0]  corr_cnt;
  logic [1:0]  uncorr_cnt;

  matrix_code_dec_pipe #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_status(out_status), .out_err_row(out_err_row), .out_err_col(out_err_col),
    .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  st;
    logic [1:0]  r;
    logic [1:0]  c;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  bit   clr_rand = 1'b0;
  int   m_corr = 0;
  int   m_uncorr = 0;
  bit   hold_v = 1'b0;
  logic [21:0] hold_val;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [24:0] encode(input logic [15:0] d);
    logic [24:0] cw;
    cw = '0;
    cw[15:0] = d;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        cw[16+r] = cw[16+r] ^ d[r*4+c];
        cw[20+c] = cw[20+c] ^ d[r*4+c];
      end
    cw[24] = ^cw[23:0];
    return cw;
  endfunction

  // Expected response follows directly from what was injected, not from syndromes.
  task automatic send(input logic [15:0] d, input int nf, input int p0, input int p1);
    logic [24:0] cw;
    exp_t e;
    int n;
    bit ok;
    cw = encode(d);
    if (nf >= 1) cw[p0] = ~cw[p0];
    if (nf >= 2) cw[p1] = ~cw[p1];
    e.d   = (nf == 2) ? cw[15:0] : d;
    e.st  = (nf == 0) ? 2'd0 : (nf == 2) ? 2'd3 : (p0 < 16) ? 2'd1 : 2'd2;
    e.r   = (nf == 1 && p0 < 16) ? 2'(p0 / 4) : 2'd0;
    e.c   = (nf == 1 && p0 < 16) ? 2'(p0 % 4) : 2'd0;
    in_valid = 1'b1;
    in_cw    = cw;
    n  = 0;
    ok = 1'b0;
    while (!ok && n <= 500) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    if (ok) begin
      e.cyc = cyc;
      e.lat = (rdy_mode == 0);
      q.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready stuck at 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d expected=0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard pop, hold-stability and counter model.
  always @(negedge clk) begin
    exp_t e;
    bit hs;
    if (!rst_n) begin
      m_corr   = 0;
      m_uncorr = 0;
      hold_v   = 1'b0;
    end else begin
      hs = out_valid && out_ready;
      chk("corr_cnt", 32'(corr_cnt), 32'(m_corr));
      chk("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
      if (hold_v) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_payload", 32'({out_data, out_status, out_err_row, out_err_col}), 32'(hold_val));
      end
      if (hs) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output data=%h status=%0d expected none", out_data, out_status);
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_status", 32'(out_status), 32'(e.st));
          chk("out_err_row", 32'(out_err_row), 32'(e.r));
          chk("out_err_col", 32'(out_err_col), 32'(e.c));
          if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_val = {out_data, out_status, out_err_row, out_err_col};
`ifdef MCD_ERR_CNT_EN
      if (cnt_clr) begin
        m_corr   = 0;
        m_uncorr = 0;
      end else if (hs) begin
        if (out_status == 2'd3) begin
          if (m_uncorr < 3) m_uncorr++;
        end else if (out_status != 2'd0) begin
          if (m_corr < 3) m_corr++;
        end
      end
`endif
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    if (clr_rand) cnt_clr = ($urandom_range(0, 15) == 0);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int nf, p0, p1;
    int exp_c3;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cw     = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_status", 32'(out_status), 32'd0);
    chk("rst_corr_cnt", 32'(corr_cnt), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    send(16'hA5C3, 0, 0, 0);
    send(16'hA5C3, 1, 5, 0);
    send(16'hA5C3, 1, 17, 0);
    send(16'hA5C3, 1, 24, 0);
    send(16'h1234, 2, 5, 10);
    send(16'hFFFF, 1, 0, 0);
    send(16'h0000, 1, 15, 0);
    send(16'h8001, 1, 23, 0);
    drain();

    // Stall: two words fill the pipeline, the third must wait.
    rdy_mode  = 3;
    out_ready = 1'b0;
    send(16'h1111, 0, 0, 0);
    send(16'h2222, 1, 6, 0);
    in_valid = 1'b1;
    in_cw    = encode(16'h3333);
    @(negedge clk);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'h3333, 0, 0, 0);
    send(16'h4444, 1, 20, 0);
    send(16'h5555, 2, 1, 22);
    send(16'h6666, 0, 0, 0);
    rdy_mode = 0;
    drain();

    // Counter saturation and clear priority.
`ifdef MCD_ERR_CNT_EN
    exp_c3 = 3;
`else
    exp_c3 = 0;
`endif
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    send(16'hBEEF, 1, 5, 0);
    send(16'hBEEF, 1, 17, 0);
    send(16'hBEEF, 1, 24, 0);
    send(16'hBEEF, 2, 3, 19);
    drain();
    chk("cnt_corr_3", 32'(corr_cnt), 32'(exp_c3));
    chk("cnt_uncorr_1", 32'(uncorr_cnt), (exp_c3 == 3) ? 32'd1 : 32'd0);
    send(16'hCAFE, 1, 9, 0);
    send(16'hCAFE, 1, 21, 0);
    drain();
    chk("cnt_corr_sat", 32'(corr_cnt), 32'(exp_c3));
    send(16'hD00D, 1, 12, 0);
    cnt_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    drain();
    chk("cnt_clr_corr", 32'(corr_cnt), 32'd0);
    chk("cnt_clr_uncorr", 32'(uncorr_cnt), 32'd0);

    // Reset with two words in flight; nothing may emerge afterwards.
    send(16'h0F0F, 1, 2, 0);
    send(16'hF0F0, 2, 0, 7);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_corr_cnt", 32'(corr_cnt), 32'd0);
    chk("midrst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    chk("midrst_out_status", 32'(out_status), 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;

    // Random traffic with random back-pressure and clears.
    rdy_mode = 1;
    clr_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      nf = $urandom_range(0, 2);
      p0 = $urandom_range(0, CW_W - 1);
      p1 = (p0 + 1 + $urandom_range(0, CW_W - 2)) % CW_W;
      send(16'($urandom), nf, p0, p1);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    drain();
    clr_rand = 1'b0;
    cnt_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
